inside_multi: RTL and testbench
===============================

INSIDE_MULTI -- requirements
Module: inside_multi

Interface
REQ-001 SHALL have parameter N, default 8: coordinate width in bits; coordinates are two's complement, radii are unsigned N+1 bits.
REQ-002 SHALL have parameter K, default 4: number of anchors, K >= 1.
REQ-003 SHALL have parameter MODE, default 0: decision mode; 0 = ALL (inside every anchor), 1 = ANY (inside at least one), 2 = THRESH (inside at least THRESH anchors).
REQ-004 SHALL have parameter THRESH, default 2: minimum hit count, used only when MODE=2; THRESH=0 always yields o=1.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have port start, input, 1 bit: request to evaluate; accepted only in IDLE.
REQ-008 SHALL have port g_input, input, 2N bits: device point; [2N-1:N] = xD, [N-1:0] = yD.
REQ-009 SHALL have port e_input, input, K*(3N+1) bits: anchor k occupies [(k+1)(3N+1)-1 : k(3N+1)], packed inside the slice as {xA[N-1:0], yA[N-1:0], rA[N:0]}.
REQ-010 SHALL have port busy, output, 1 bit: high from acceptance of start until done.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse when results become valid.
REQ-012 SHALL have port mask, output, K bits: bit k = 1 if D is inside anchor k.
REQ-013 SHALL have port count, output, $clog2(K+1) bits: popcount of mask.
REQ-014 SHALL have port o, output, 1 bit: decision per MODE.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, FLUSH: IDLE->RUN on start; RUN->FLUSH after issuing anchor K-1; FLUSH->IDLE when the last result retires.
REQ-016 SHALL latch g_input and e_input into internal registers on the edge that accepts start (edge T0); later input changes SHALL NOT affect the running evaluation.
REQ-017 SHALL issue one anchor per cycle, index 0..K-1, using a single shared datapath.
REQ-018 SHALL, in pipeline stage 1, compute dx = xD - xA and dy = yD - yA as (N+1)-bit signed values with no overflow.
REQ-019 SHALL, in pipeline stage 2, compute s = dx*dx + dy*dy and r2 = rA*rA, each as 2N+2-bit unsigned values.
REQ-020 SHALL, in pipeline stage 3, set mask[k] = (s <= r2); the test is inclusive, so a point on the circle is inside.
REQ-021 SHALL write the result of anchor i at edge T0+3+i.
REQ-022 SHALL assert done for exactly one cycle, following edge T0+K+2, and SHALL update o and count on that same edge.
REQ-023 SHALL hold mask, count and o stable from done until the next accepted start; mask SHALL clear to 0 at acceptance of a new start.
REQ-024 SHALL ignore start while busy=1, with no restart and no queuing; start held high through done SHALL begin a new evaluation on the first IDLE cycle.
REQ-025 SHALL compute o as: MODE=0 -> count==K; MODE=1 -> count!=0; MODE=2 -> count>=THRESH.
REQ-026 SHALL work correctly for K=1: RUN lasts one cycle and done follows edge T0+3.

Reset
REQ-027 SHALL, while rst_n=0 at a clock edge, go to IDLE and force busy=0, done=0, mask=0, count=0, o=0.
REQ-028 SHALL, on reset asserted mid-evaluation, abandon the evaluation, produce no done pulse, and flush all pipeline contents.
REQ-029 SHALL accept start on the first edge after rst_n returns high.

Verification
REQ-030 SHALL cover N=8, K=1, D=(4,41), A=(-92,108), r=195 -> s=13705 <= 38025, mask=1, o=1, done pulses 3 cycles after start.
REQ-031 SHALL cover the same anchor with D=(112,-20) -> s=58000 > 38025, mask=0, o=0, count=0.
REQ-032 SHALL cover boundary and extremes: D=(0,0), A=(3,4), r=5 -> inside (25<=25); D=(-128,-128), A=(127,127), r=511 -> s=130050, inside; the same with r=0 -> outside.
REQ-033 SHALL cover K=4 with hits {1,0,1,1} -> mask=4'b1101, count=3; o=0 for MODE 0, o=1 for MODE 1, o=1 for MODE 2 with THRESH 2; done follows edge T0+6.
REQ-034 SHALL cover a start pulse while busy, plus e_input changes after T0 -> results match the latched inputs, and exactly one done pulse.
REQ-035 SHALL cover rst_n low for one cycle at T0+2 with K=4 -> no done pulse, all outputs 0, and a new start after reset completes normally.

Source files
------------

// File: rtl/inside_multi.sv
// inside_multi: tests a device point against K circular anchors, one anchor
// per cycle through a shared 3-stage datapath, then reduces the hits by MODE.
//
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   start       - begin an evaluation (taken only when idle)
//   g_input     - device point {xD, yD}, two's complement, N bits each
//   e_input     - K anchors, anchor k at slice k, packed {xA, yA, rA}
//   busy        - evaluation in progress
//   done        - one-cycle pulse, results valid
//   mask        - per-anchor inside flags
//   count       - number of set mask bits
//   o           - decision: ALL / ANY / at least THRESH
module inside_multi #(
  parameter int N      = 8,
  parameter int K      = 4,
  parameter int MODE   = 0,
  parameter int THRESH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [2*N-1:0]           g_input,
  input  logic [K*(3*N+1)-1:0]     e_input,
  output logic                     busy,
  output logic                     done,
  output logic [K-1:0]             mask,
  output logic [$clog2(K+1)-1:0]   count,
  output logic                     o
);

  localparam int W  = 3 * N + 1;
  localparam int IW = (K > 1) ? $clog2(K) : 1;
  localparam int SW = 2 * N + 2;
  localparam int CW = $clog2(K + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  localparam logic [IW-1:0] LAST = IW'(K - 1);

  logic [1:0]         state;
  logic [IW-1:0]      idx;
  logic [2*N-1:0]     g_q;
  logic [K*W-1:0]     e_q;

  // stage 1 registers
  logic               v1;
  logic               l1;
  logic [IW-1:0]      i1;
  logic [N:0]         dx1;
  logic [N:0]         dy1;
  logic [N:0]         ra1;

  // stage 2 registers
  logic               v2;
  logic               l2;
  logic [IW-1:0]      i2;
  logic [SW-1:0]      s2;
  logic [SW-1:0]      r22;

  // issue-side combinational
  logic [W-1:0]       anc;
  logic [N-1:0]       xa;
  logic [N-1:0]       ya;
  logic [N:0]         ra;
  logic [N-1:0]       xd;
  logic [N-1:0]       yd;
  logic [N:0]         dx_n;
  logic [N:0]         dy_n;

  // stage 2 combinational
  logic [SW-1:0]      dxe;
  logic [SW-1:0]      dye;
  logic [SW-1:0]      rae;
  logic [SW-1:0]      s_n;
  logic [SW-1:0]      r2_n;

  // stage 3 combinational
  logic               hit;
  logic [K-1:0]       mask_n;
  logic [CW-1:0]      cnt_n;
  logic               o_n;

  assign busy = (state != S_IDLE);

  always_comb begin
    anc = '0;
    for (int k = 0; k < K; k++) begin
      if (idx == IW'(k)) anc = e_q[k*W +: W];
    end
  end

  assign xa = anc[3*N:2*N+1];
  assign ya = anc[2*N:N+1];
  assign ra = anc[N:0];
  assign xd = g_q[2*N-1:N];
  assign yd = g_q[N-1:0];

  // one extra bit makes the difference exact
  assign dx_n = {xd[N-1], xd} - {xa[N-1], xa};
  assign dy_n = {yd[N-1], yd} - {ya[N-1], ya};

  // sign-extended squares: low SW bits are exact and non-negative
  assign dxe  = {{(N+1){dx1[N]}}, dx1};
  assign dye  = {{(N+1){dy1[N]}}, dy1};
  assign rae  = {{(N+1){1'b0}}, ra1};
  assign s_n  = dxe * dxe + dye * dye;
  assign r2_n = rae * rae;

  assign hit = (s2 <= r22);

  always_comb begin
    mask_n = mask;
    for (int k = 0; k < K; k++) begin
      if (v2 && i2 == IW'(k)) mask_n[k] = hit;
    end
  end

  always_comb begin
    cnt_n = '0;
    for (int k = 0; k < K; k++) begin
      cnt_n = cnt_n + CW'(mask_n[k]);
    end
  end

  always_comb begin
    o_n = 1'b0;
    if (MODE == 0) begin
      o_n = (int'(cnt_n) == K);
    end else if (MODE == 1) begin
      o_n = (cnt_n != '0);
    end else begin
      o_n = (int'(cnt_n) >= THRESH);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      idx   <= '0;
      g_q   <= '0;
      e_q   <= '0;
      v1    <= 1'b0;
      l1    <= 1'b0;
      i1    <= '0;
      dx1   <= '0;
      dy1   <= '0;
      ra1   <= '0;
      v2    <= 1'b0;
      l2    <= 1'b0;
      i2    <= '0;
      s2    <= '0;
      r22   <= '0;
      done  <= 1'b0;
      mask  <= '0;
      count <= '0;
      o     <= 1'b0;
    end else begin
      done <= 1'b0;

      unique case (state)
        S_IDLE: begin
          if (start) begin
            g_q   <= g_input;
            e_q   <= e_input;
            mask  <= '0;
            idx   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if (idx == LAST) begin
            state <= S_FLUSH;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_FLUSH: begin
          if (v2 && l2) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      v1  <= (state == S_RUN);
      l1  <= (state == S_RUN) && (idx == LAST);
      i1  <= idx;
      dx1 <= dx_n;
      dy1 <= dy_n;
      ra1 <= ra;

      v2  <= v1;
      l2  <= v1 && l1;
      i2  <= i1;
      s2  <= s_n;
      r22 <= r2_n;

      if (v2) begin
        mask <= mask_n;
        if (l2) begin
          count <= cnt_n;
          o     <= o_n;
          done  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_inside_multi.sv
// tb_inside_multi: scoreboard bench for inside_multi (K=1 and K=4 in
// three decision modes); expected results are queued at start acceptance.
module tb_inside_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         start1;
  logic         start4;
  logic [15:0]  g1;
  logic [15:0]  g4;
  logic [24:0]  e1;
  logic [99:0]  e4;

  logic         busy1, done1, o1;
  logic [0:0]   mask1;
  logic [0:0]   cnt1;

  logic         busya, donea, oa;
  logic [3:0]   maska;
  logic [2:0]   cnta;
  logic         busyb, doneb, ob;
  logic [3:0]   maskb;
  logic [2:0]   cntb;
  logic         busyc, donec, oc;
  logic [3:0]   maskc;
  logic [2:0]   cntc;

  inside_multi #(.N(8), .K(1), .MODE(0), .THRESH(2)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .g_input(g1), .e_input(e1),
    .busy(busy1), .done(done1), .mask(mask1), .count(cnt1), .o(o1)
  );

  inside_multi #(.N(8), .K(4), .MODE(0), .THRESH(2)) ua (
    .clk(clk), .rst_n(rst_n), .start(start4),
    .g_input(g4), .e_input(e4),
    .busy(busya), .done(donea), .mask(maska), .count(cnta), .o(oa)
  );

  inside_multi #(.N(8), .K(4), .MODE(1), .THRESH(2)) ub (
    .clk(clk), .rst_n(rst_n), .start(start4),
    .g_input(g4), .e_input(e4),
    .busy(busyb), .done(doneb), .mask(maskb), .count(cntb), .o(ob)
  );

  inside_multi #(.N(8), .K(4), .MODE(2), .THRESH(2)) uc (
    .clk(clk), .rst_n(rst_n), .start(start4),
    .g_input(g4), .e_input(e4),
    .busy(busyc), .done(donec), .mask(maskc), .count(cntc), .o(oc)
  );

  typedef struct {
    int m;
    int c;
    int o;
    int due;
  } exp_t;

  exp_t q1[$];
  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];
  exp_t x1, xa, xb, xc;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic cmp(input string nm, input exp_t x,
                     input int m, input int c, input int o);
    chk({nm, " mask"}, m, x.m);
    chk({nm, " count"}, c, x.c);
    chk({nm, " o"}, o, x.o);
    chk({nm, " done edge"}, cyc, x.due);
  endtask

  task automatic stray(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: got done expected none", nm);
  endtask

  always @(negedge clk) begin
    if (done1) begin
      if (q1.size() == 0) stray("u1 unexpected done");
      else begin
        x1 = q1.pop_front();
        cmp("u1", x1, int'(mask1), int'(cnt1), int'(o1));
      end
    end
    if (donea) begin
      if (qa.size() == 0) stray("ua unexpected done");
      else begin
        xa = qa.pop_front();
        cmp("ua", xa, int'(maska), int'(cnta), int'(oa));
      end
    end
    if (doneb) begin
      if (qb.size() == 0) stray("ub unexpected done");
      else begin
        xb = qb.pop_front();
        cmp("ub", xb, int'(maskb), int'(cntb), int'(ob));
      end
    end
    if (donec) begin
      if (qc.size() == 0) stray("uc unexpected done");
      else begin
        xc = qc.pop_front();
        cmp("uc", xc, int'(maskc), int'(cntc), int'(oc));
      end
    end
  end

  function automatic logic [24:0] anc(input int x, input int y, input int r);
    return {x[7:0], y[7:0], r[8:0]};
  endfunction

  function automatic logic [15:0] pt(input int x, input int y);
    return {x[7:0], y[7:0]};
  endfunction

  task automatic go1(input logic [15:0] g, input logic [24:0] e,
                     input int m, input int c, input int o);
    @(negedge clk);
    g1 = g;
    e1 = e;
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    q1.push_back('{m, c, o, cyc + 3});
    chk("u1 busy after start", int'(busy1), 1);
    e1 = ~e;
    g1 = ~g;
    repeat (5) @(negedge clk);
    chk("u1 busy idle", int'(busy1), 0);
  endtask

  task automatic go4(input logic [15:0] g, input logic [99:0] e,
                     input int m, input int c,
                     input int o0, input int o1v, input int o2);
    @(negedge clk);
    g4 = g;
    e4 = e;
    start4 = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    qa.push_back('{m, c, o0, cyc + 6});
    qb.push_back('{m, c, o1v, cyc + 6});
    qc.push_back('{m, c, o2, cyc + 6});
    e4 = ~e;
    repeat (8) @(negedge clk);
  endtask

  logic [99:0] e_h1101, e_miss, e_h0010, e_hall, e_h0011;

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    e_h1101 = {anc(0, 0, 0), anc(-10, 0, 10), anc(3, 4, 4), anc(3, 4, 5)};
    e_miss  = {anc(1, 0, 0), anc(1, 0, 0), anc(1, 0, 0), anc(1, 0, 0)};
    e_h0010 = {anc(0, 0, 14), anc(0, 0, 14), anc(10, 10, 0), anc(0, 0, 14)};
    e_hall  = {4{anc(127, 127, 511)}};
    e_h0011 = {anc(1, 0, 0), anc(1, 0, 0), anc(0, 0, 0), anc(3, 4, 5)};

    rst_n  = 1'b0;
    start1 = 1'b0;
    start4 = 1'b0;
    g1 = '0;
    e1 = '0;
    g4 = '0;
    e4 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset u1 busy", int'(busy1), 0);
    chk("reset u1 done", int'(done1), 0);
    chk("reset u1 mask", int'(mask1), 0);
    chk("reset ua busy", int'(busya), 0);
    chk("reset ua count", int'(cnta), 0);
    chk("reset ua o", int'(oa), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // K=1 vectors
    go1(pt(4, 41), anc(-92, 108, 195), 1, 1, 1);
    go1(pt(112, -20), anc(-92, 108, 195), 0, 0, 0);
    go1(pt(0, 0), anc(3, 4, 5), 1, 1, 1);
    go1(pt(-128, -128), anc(127, 127, 511), 1, 1, 1);
    go1(pt(-128, -128), anc(127, 127, 0), 0, 0, 0);

    // start held high through done: second run on first idle cycle
    @(negedge clk);
    g1 = pt(4, 41);
    e1 = anc(-92, 108, 195);
    start1 = 1'b1;
    @(posedge clk);
    #1;
    q1.push_back('{1, 1, 1, cyc + 3});
    q1.push_back('{1, 1, 1, cyc + 7});
    repeat (4) @(posedge clk);
    #1;
    start1 = 1'b0;
    repeat (6) @(negedge clk);

    // K=4 vectors
    go4(pt(0, 0), e_h1101, 13, 3, 0, 1, 1);
    go4(pt(0, 0), e_miss, 0, 0, 0, 0, 0);
    go4(pt(10, 10), e_h0010, 2, 1, 0, 1, 0);
    go4(pt(-128, -128), e_hall, 15, 4, 1, 1, 1);
    go4(pt(0, 0), e_h0011, 3, 2, 0, 1, 1);

    // start pulse while busy plus e_input change after acceptance
    @(negedge clk);
    g4 = pt(0, 0);
    e4 = e_h1101;
    start4 = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    qa.push_back('{13, 3, 0, cyc + 6});
    qb.push_back('{13, 3, 1, cyc + 6});
    qc.push_back('{13, 3, 1, cyc + 6});
    @(negedge clk);
    @(negedge clk);
    start4 = 1'b1;
    e4 = e_miss;
    chk("ua busy mid-run", int'(busya), 1);
    @(negedge clk);
    start4 = 1'b0;
    repeat (8) @(negedge clk);

    // reset at T0+2: evaluation abandoned, no done
    @(negedge clk);
    g4 = pt(0, 0);
    e4 = e_h1101;
    start4 = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst ua busy", int'(busya), 0);
    chk("rst ua done", int'(donea), 0);
    chk("rst ua mask", int'(maska), 0);
    chk("rst ua count", int'(cnta), 0);
    chk("rst ua o", int'(oa), 0);
    chk("rst ub o", int'(ob), 0);
    chk("rst uc count", int'(cntc), 0);
    repeat (10) @(negedge clk);

    go4(pt(0, 0), e_h1101, 13, 3, 0, 1, 1);

    repeat (4) @(negedge clk);
    chk("u1 pending results", q1.size(), 0);
    chk("ua pending results", qa.size(), 0);
    chk("ub pending results", qb.size(), 0);
    chk("uc pending results", qc.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
